// File: rtl/ram_pkg.sv
// Shared types for the dual-port RAM: per-port read-data source selection.
package ram_pkg;

    typedef enum logic [1:0] {
        RD_HOLD,
        RD_MEM,
        RD_WDATA
    } rd_src_e;

    // A port that reads and writes in the same cycle sees its own write data.
    function automatic rd_src_e rd_src(input logic rden, input logic wren);
        if (!rden)
            return RD_HOLD;
        else if (wren)
            return RD_WDATA;
        else
            return RD_MEM;
    endfunction

endpackage

// File: rtl/ram_port.sv
// One RAM port: selects the read-data source and holds the registered q output.
module ram_port
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rden_i,
    input  logic                  wren_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [DATA_WIDTH-1:0] mem_rd_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DATA_WIDTH-1:0] q_q;
    logic [DATA_WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        unique case (rd_src(rden_i, wren_i))
            RD_MEM:   q_d = mem_rd_i;
            RD_WDATA: q_d = data_i;
            default:  q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/ram.sv
// True dual-port RAM, single clock, 1-cycle registered reads, port A wins write collisions.
module ram
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic                  wren_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  rden_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic                  wren_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  rden_b,
    output logic [DATA_WIDTH-1:0] q_b
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Contents start at zero; the array itself is never reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    // Pre-edge contents, so a cross-port read of a just-written word sees old data.
    assign rd_a = mem[address_a];
    assign rd_b = mem[address_b];

    // Port A is written last so it overrides port B on a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wren_b)
                mem[address_b] <= data_b;
            if (wren_a)
                mem[address_a] <= data_a;
        end
    end

    ram_port #(.DATA_WIDTH(DATA_WIDTH)) u_port_a (
        .clk      (clk),
        .rst      (rst),
        .rden_i   (rden_a),
        .wren_i   (wren_a),
        .data_i   (data_a),
        .mem_rd_i (rd_a),
        .q_o      (q_a)
    );

    ram_port #(.DATA_WIDTH(DATA_WIDTH)) u_port_b (
        .clk      (clk),
        .rst      (rst),
        .rden_i   (rden_b),
        .wren_i   (wren_b),
        .data_i   (data_b),
        .mem_rd_i (rd_b),
        .q_o      (q_b)
    );

endmodule

// File: tb/tb_ram.sv
// Directed self-checking bench for the dual-port RAM.
module tb_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] address_a = '0;
    logic        wren_a = 1'b0;
    logic [31:0] data_a = '0;
    logic        rden_a = 1'b0;
    logic [31:0] q_a;
    logic [10:0] address_b = '0;
    logic        wren_b = 1'b0;
    logic [31:0] data_b = '0;
    logic        rden_b = 1'b0;
    logic [31:0] q_b;

    int total = 0;
    int bad   = 0;

    ram #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .address_a (address_a),
        .wren_a    (wren_a),
        .data_a    (data_a),
        .rden_a    (rden_a),
        .q_a       (q_a),
        .address_b (address_b),
        .wren_b    (wren_b),
        .data_b    (data_b),
        .rden_b    (rden_b),
        .q_b       (q_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wren_a = 1'b0; rden_a = 1'b0;
        wren_b = 1'b0; rden_b = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        total++;
        if (q_a !== 32'h0) begin bad++; $display("FAIL reset_qa got=%h exp=%h", q_a, 32'h0); end
        total++;
        if (q_b !== 32'h0) begin bad++; $display("FAIL reset_qb got=%h exp=%h", q_b, 32'h0); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (q_a !== 32'h0 || q_b !== 32'h0) begin
            bad++; $display("FAIL post_reset_idle got=%h/%h exp=0/0", q_a, q_b);
        end
    endtask

    task automatic test_powerup();
        rden_b = 1'b1; address_b = 11'd2047;
        rden_a = 1'b1; address_a = 11'd0;
        tick();
        idle();
        total++;
        if (q_b !== 32'h0) begin bad++; $display("FAIL powerup_b2047 got=%h exp=%h", q_b, 32'h0); end
        total++;
        if (q_a !== 32'h0) begin bad++; $display("FAIL powerup_a0 got=%h exp=%h", q_a, 32'h0); end
    endtask

    task automatic test_write_read();
        wren_a = 1'b1; address_a = 11'd5; data_a = 32'hDEADBEEF;
        wren_b = 1'b1; address_b = 11'd100; data_b = 32'hCAFEF00D;
        tick();
        idle();
        rden_b = 1'b1; address_b = 11'd5;
        rden_a = 1'b1; address_a = 11'd100;
        tick();
        idle();
        total++;
        if (q_b !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_a_rd_b got=%h exp=%h", q_b, 32'hDEADBEEF); end
        total++;
        if (q_a !== 32'hCAFEF00D) begin bad++; $display("FAIL wr_b_rd_a got=%h exp=%h", q_a, 32'hCAFEF00D); end
        address_a = 11'd0; address_b = 11'd0;
        tick();
        total++;
        if (q_b !== 32'hDEADBEEF) begin bad++; $display("FAIL hold_b got=%h exp=%h", q_b, 32'hDEADBEEF); end
    endtask

    task automatic test_mixed_rdw();
        wren_a = 1'b1; address_a = 11'd7; data_a = 32'h11111111;
        tick();
        data_a = 32'h22222222;
        rden_b = 1'b1; address_b = 11'd7;
        tick();
        idle();
        total++;
        if (q_b !== 32'h11111111) begin bad++; $display("FAIL mixed_rdw_old got=%h exp=%h", q_b, 32'h11111111); end
        rden_b = 1'b1;
        tick();
        idle();
        total++;
        if (q_b !== 32'h22222222) begin bad++; $display("FAIL mixed_rdw_new got=%h exp=%h", q_b, 32'h22222222); end
    endtask

    task automatic test_collision();
        wren_a = 1'b1; address_a = 11'd3; data_a = 32'hAAAAAAAA;
        wren_b = 1'b1; address_b = 11'd3; data_b = 32'h55555555;
        tick();
        idle();
        rden_a = 1'b1; rden_b = 1'b1;
        tick();
        idle();
        total++;
        if (q_a !== 32'hAAAAAAAA) begin bad++; $display("FAIL collide_a got=%h exp=%h", q_a, 32'hAAAAAAAA); end
        total++;
        if (q_b !== 32'hAAAAAAAA) begin bad++; $display("FAIL collide_b got=%h exp=%h", q_b, 32'hAAAAAAAA); end
    endtask

    task automatic test_write_through();
        wren_a = 1'b1; rden_a = 1'b1; address_a = 11'd9; data_a = 32'h12345678;
        tick();
        idle();
        total++;
        if (q_a !== 32'h12345678) begin bad++; $display("FAIL write_through got=%h exp=%h", q_a, 32'h12345678); end
        address_a = 11'd5; data_a = 32'h0;
        tick();
        tick();
        total++;
        if (q_a !== 32'h12345678) begin bad++; $display("FAIL rden0_hold got=%h exp=%h", q_a, 32'h12345678); end
    endtask

    task automatic test_reset_mid();
        rden_b = 1'b1; address_b = 11'd5;
        tick();
        idle();
        #2;
        rst = 1'b1;
        wren_a = 1'b1; rden_a = 1'b1; address_a = 11'd9; data_a = 32'hFFFFFFFF;
        #1;
        total++;
        if (q_a !== 32'h0) begin bad++; $display("FAIL async_rst_qa got=%h exp=%h", q_a, 32'h0); end
        total++;
        if (q_b !== 32'h0) begin bad++; $display("FAIL async_rst_qb got=%h exp=%h", q_b, 32'h0); end
        tick();
        total++;
        if (q_a !== 32'h0) begin bad++; $display("FAIL rst_read_ignored got=%h exp=%h", q_a, 32'h0); end
        rst = 1'b0;
        wren_a = 1'b0; rden_a = 1'b1; address_a = 11'd9;
        tick();
        idle();
        total++;
        if (q_a !== 32'h12345678) begin bad++; $display("FAIL retained_after_rst got=%h exp=%h", q_a, 32'h12345678); end
    endtask

    task automatic test_back_to_back();
        wren_a = 1'b1; address_a = 11'd40; data_a = 32'h40404040;
        wren_b = 1'b1; address_b = 11'd41; data_b = 32'h41414141;
        tick();
        idle();
        rden_a = 1'b1; address_a = 11'd41;
        wren_b = 1'b1; address_b = 11'd42; data_b = 32'h42424242;
        tick();
        idle();
        total++;
        if (q_a !== 32'h41414141) begin bad++; $display("FAIL b2b_a41 got=%h exp=%h", q_a, 32'h41414141); end
        rden_a = 1'b1; address_a = 11'd42;
        rden_b = 1'b1; address_b = 11'd40;
        tick();
        idle();
        total++;
        if (q_a !== 32'h42424242) begin bad++; $display("FAIL b2b_a42 got=%h exp=%h", q_a, 32'h42424242); end
        total++;
        if (q_b !== 32'h40404040) begin bad++; $display("FAIL b2b_b40 got=%h exp=%h", q_b, 32'h40404040); end
        address_b = 11'd41;
        tick();
        total++;
        if (q_b !== 32'h40404040) begin bad++; $display("FAIL b2b_hold_b got=%h exp=%h", q_b, 32'h40404040); end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_write_read();
        test_mixed_rdw();
        test_collision();
        test_write_through();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram.md
RAM -- requirements
Module: ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, address bits per port; depth = 2**ADDR_WIDTH words; first positional parameter.
REQ-002 Parameter DATA_WIDTH, default 32, word width for data_a, data_b, q_a, q_b.
REQ-003 clk  input  1  single clock for both ports; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 address_a  input  ADDR_WIDTH  port A word address.
REQ-006 wren_a  input  1  port A write enable.
REQ-007 data_a  input  DATA_WIDTH  port A write data.
REQ-008 rden_a  input  1  port A read enable.
REQ-009 q_a  output  DATA_WIDTH  port A registered read data.
REQ-010 address_b  input  ADDR_WIDTH  port B word address.
REQ-011 wren_b  input  1  port B write enable.
REQ-012 data_b  input  DATA_WIDTH  port B write data.
REQ-013 rden_b  input  1  port B read enable.
REQ-014 q_b  output  DATA_WIDTH  port B registered read data.

Function
REQ-015 True dual-port memory; both ports independently read or write one word per cycle.
REQ-016 Write: wren_x=1 at a rising edge stores data_x at address_x at that edge.
REQ-017 Read latency 1 cycle: rden_x=1 at edge N drives q_x with word at address_x from edge N until next update.
REQ-018 rden_x=0: q_x holds its previous value.
REQ-019 Same-port read-during-write (rden_x=1, wren_x=1): q_x returns new data_x (write-through).
REQ-020 Mixed-port read-during-write (port reads address the other port writes same edge): reader returns old contents.
REQ-021 Both ports write same address same edge: port A data stored; port B write discarded.
REQ-022 Addresses exactly ADDR_WIDTH bits; no out-of-range case; callers truncate wider address expressions.
REQ-023 Memory array contents initialised to all zero at power-up/configuration.
REQ-024 No handshake; every enabled access completes in the cycle it is presented.

Reset
REQ-025 rst=1 forces q_a and q_b to 0 immediately, without waiting for clk.
REQ-026 While rst=1, writes and reads are ignored; memory contents are not cleared and are retained across reset.
REQ-027 First access after rst deasserts is accepted at the first rising edge with rst=0.

Structure
REQ-028 No shared package needed; ADDR_WIDTH/DATA_WIDTH are module parameters only.
REQ-029 One optional sub-module, ram_port (address/enable/data-in/q register for one port), instantiated twice around a single shared array; array coded for block-RAM inference.

Verification
REQ-030 Write 0xDEADBEEF to A addr 5, then rden_b at addr 5 -> q_b=0xDEADBEEF one cycle later.
REQ-031 After power-up, read B addr 2047 -> q_b=0x00000000.
REQ-032 Addr 7 holds 0x11111111; same edge A writes 0x22222222 to addr 7 and B reads addr 7 -> q_b=0x11111111; next B read -> 0x22222222.
REQ-033 Same edge A writes 0xAAAAAAAA, B writes 0x55555555 to addr 3 -> later read addr 3 = 0xAAAAAAAA.
REQ-034 A write+read addr 9 with 0x12345678 same edge -> q_a=0x12345678 next cycle; then rden_a=0 -> q_a holds 0x12345678.
REQ-035 Assert rst mid-cycle with q_a=0x12345678 -> q_a=0 before next edge; addr 9 still reads 0x12345678 after release.
